// File: rtl/dvp_pattern_gen.sv
// DVP camera-stream source: vsync/href/byte bus with selectable test patterns.
// Drives format_converter during bring-up when no sensor is attached.
module dvp_pattern_gen #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int BPP     = 2,
    parameter int H_BLANK = 100,
    parameter int VS_PRE  = 10,
    parameter int VS_W    = 10,
    parameter int V_BP    = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
    input  logic [7:0]  num_frames,
    input  logic [15:0] const_color,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  din,
    output logic        busy,
    output logic        frame_done
);

    localparam int LBYTES = H_ACT * BPP;
    localparam int MAX1   = (LBYTES > H_BLANK) ? LBYTES : H_BLANK;
    localparam int MAX2   = (MAX1 > VS_PRE) ? MAX1 : VS_PRE;
    localparam int MAX3   = (MAX2 > VS_W) ? MAX2 : VS_W;
    localparam int CMAX   = (MAX3 > V_BP) ? MAX3 : V_BP;
    localparam int CNT_W  = $clog2(CMAX + 1);
    localparam int LN_W   = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int BAR_W  = (H_ACT >= 8) ? (H_ACT / 8) : 1;
    localparam logic [15:0] BAR_WL = 16'(BAR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VS_PRE,
        S_VS_HI,
        S_VS_BP,
        S_LINE,
        S_HBLK,
        S_FEND
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [LN_W-1:0]  r_line;
    logic [7:0]       r_ctr;
    logic [1:0]       r_mode;
    logic [7:0]       r_num;
    logic [15:0]      r_color;
    logic [7:0]       r_fcnt;
    logic             r_stop;

    logic [15:0] w_idx;
    logic [15:0] w_x;
    logic [15:0] w_y;
    logic        w_lo;
    logic [15:0] w_bar;
    logic [2:0]  w_bar_c;
    logic [15:0] w_bar_px;
    logic [15:0] w_chk;
    logic [15:0] w_pix;
    logic [7:0]  w_byte;
    logic        w_last_frame;

    // Coordinates of the byte presented on the cycle after this edge.
    always_comb begin
        w_idx = (r_state == S_LINE) ? (16'(r_cnt) + 16'd1) : 16'd0;
        w_y   = (r_state == S_HBLK) ? (16'(r_line) + 16'd1) : 16'(r_line);
        w_x   = (BPP == 2) ? (w_idx >> 1) : w_idx;
        w_lo  = (BPP == 2) ? w_idx[0] : 1'b0;
    end

    always_comb begin
        w_bar   = w_x / BAR_WL;
        w_bar_c = (w_bar > 16'd7) ? 3'd7 : w_bar[2:0];
        case (w_bar_c)
            3'd0:    w_bar_px = 16'hFFFF;
            3'd1:    w_bar_px = 16'hFFE0;
            3'd2:    w_bar_px = 16'h07FF;
            3'd3:    w_bar_px = 16'h07E0;
            3'd4:    w_bar_px = 16'hF81F;
            3'd5:    w_bar_px = 16'hF800;
            3'd6:    w_bar_px = 16'h001F;
            default: w_bar_px = 16'h0000;
        endcase
    end

    always_comb begin
        w_chk = ((w_x >> 4) ^ (w_y >> 4)) & 16'd1;
        case (r_mode)
            2'd1:    w_pix = w_bar_px;
            2'd2:    w_pix = (w_chk != 16'd0) ? 16'h0000 : 16'hFFFF;
            2'd3:    w_pix = r_color;
            default: w_pix = 16'h0000;
        endcase
        if (r_mode == 2'd0) begin
            w_byte = r_ctr;
        end else begin
            w_byte = w_lo ? w_pix[7:0] : w_pix[15:8];
        end
    end

    assign w_last_frame = r_stop || stop ||
                          ((r_num != 8'd0) && ((r_fcnt + 8'd1) == r_num));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_line     <= '0;
            r_ctr      <= 8'd0;
            r_mode     <= 2'd0;
            r_num      <= 8'd0;
            r_color    <= 16'd0;
            r_fcnt     <= 8'd0;
            r_stop     <= 1'b0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            din        <= 8'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (stop && (r_state != S_IDLE)) begin
                r_stop <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_VS_PRE;
                        r_cnt   <= '0;
                        r_fcnt  <= 8'd0;
                        busy    <= 1'b1;
                    end
                end
                S_VS_PRE: begin
                    if (r_cnt == CNT_W'(VS_PRE - 1)) begin
                        r_state <= S_VS_HI;
                        r_cnt   <= '0;
                        vsync   <= 1'b1;
                        r_mode  <= mode;
                        r_num   <= num_frames;
                        r_color <= const_color;
                        r_line  <= '0;
                        r_ctr   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_VS_HI: begin
                    if (r_cnt == CNT_W'(VS_W - 1)) begin
                        r_state <= S_VS_BP;
                        r_cnt   <= '0;
                        vsync   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_VS_BP: begin
                    if (r_cnt == CNT_W'(V_BP - 1)) begin
                        r_state <= S_LINE;
                        r_cnt   <= '0;
                        href    <= 1'b1;
                        din     <= w_byte;
                        r_ctr   <= r_ctr + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LINE: begin
                    if (r_cnt == CNT_W'(LBYTES - 1)) begin
                        r_state <= S_HBLK;
                        r_cnt   <= '0;
                        href    <= 1'b0;
                        din     <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        din   <= w_byte;
                        r_ctr <= r_ctr + 8'd1;
                    end
                end
                S_HBLK: begin
                    if (r_cnt == CNT_W'(H_BLANK - 1)) begin
                        r_cnt <= '0;
                        if (r_line == LN_W'(V_ACT - 1)) begin
                            r_state    <= S_FEND;
                            frame_done <= 1'b1;
                        end else begin
                            r_state <= S_LINE;
                            r_line  <= r_line + 1'b1;
                            href    <= 1'b1;
                            din     <= w_byte;
                            r_ctr   <= r_ctr + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FEND: begin
                    r_ctr  <= 8'd0;
                    r_line <= '0;
                    r_cnt  <= '0;
                    r_fcnt <= r_fcnt + 8'd1;
                    if (w_last_frame) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        r_stop  <= 1'b0;
                    end else begin
                        r_state <= S_VS_PRE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
